// File: rtl/ac_motor_pkg.sv
// Shared definitions for the SVM sequencer: vector codes, segment index type,
// counter/sum widths and the dwell-time set record.
package ac_motor_pkg;

    localparam int unsigned T_TAST_MAX = 32767;
    localparam int unsigned CNT_W      = $clog2(T_TAST_MAX + 1);
    localparam int unsigned SUM_W      = CNT_W + 2;

    localparam logic [2:0] V0 = 3'b000;
    localparam logic [2:0] V1 = 3'b100;
    localparam logic [2:0] V2 = 3'b110;
    localparam logic [2:0] V3 = 3'b010;
    localparam logic [2:0] V4 = 3'b011;
    localparam logic [2:0] V5 = 3'b001;
    localparam logic [2:0] V6 = 3'b101;
    localparam logic [2:0] V7 = 3'b111;

    typedef enum logic [2:0] {
        SEG_V0_LEAD,
        SEG_VA_LEAD,
        SEG_VB_LEAD,
        SEG_V7,
        SEG_VB_TRAIL,
        SEG_VA_TRAIL,
        SEG_V0_TRAIL
    } seg_t;

    typedef struct packed {
        logic [2:0]       sector;
        logic [CNT_W-1:0] t0;
        logic [CNT_W-1:0] t1;
        logic [CNT_W-1:0] t2;
        logic [CNT_W-1:0] t7;
    } tset_t;

    localparam tset_t TSET_IDLE = '{sector: 3'd1, t0: '0, t1: '0, t2: '0, t7: '0};

    function automatic logic [SUM_W-1:0] widen(input logic [CNT_W-1:0] x);
        return {2'b00, x};
    endfunction

    function automatic logic [2:0] vec_code(input logic [2:0] idx);
        case (idx)
            3'd0: return V0;
            3'd1: return V1;
            3'd2: return V2;
            3'd3: return V3;
            3'd4: return V4;
            3'd5: return V5;
            3'd6: return V6;
            default: return V7;
        endcase
    endfunction

endpackage

// File: rtl/ac_motor_svm_vector_lut.sv
// Combinational map from (sector, segment) to upper-switch gate pattern.
module ac_motor_svm_vector_lut
    import ac_motor_pkg::*;
(
    input  logic [2:0] sector,
    input  seg_t       seg,
    output logic [2:0] gate
);

    logic [2:0] n_next;
    logic [2:0] va;
    logic [2:0] vb;

    // Even sectors swap the active vectors so every transition flips one leg.
    always_comb begin
        n_next = (sector == 3'd6) ? 3'd1 : sector + 3'd1;
        va     = sector[0] ? sector : n_next;
        vb     = sector[0] ? n_next : sector;
        case (seg)
            SEG_VA_LEAD, SEG_VA_TRAIL: gate = vec_code(va);
            SEG_VB_LEAD, SEG_VB_TRAIL: gate = vec_code(vb);
            SEG_V7:                    gate = V7;
            default:                   gate = V0;
        endcase
    end

endmodule

// File: rtl/ac_motor_svm_sequencer.sv
// Per-period 7-segment SVM sequencer with double-buffered dwell times,
// period counter and SAMPLE strobe.
module ac_motor_svm_sequencer
    import ac_motor_pkg::*;
#(
    parameter int unsigned F_CLK  = 100_000_000,
    parameter int unsigned F_TAST = 5_000,
    parameter int unsigned T_TAST = F_CLK / F_TAST
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        T_VALID,
    input  logic [14:0] T_0,
    input  logic [14:0] T_1,
    input  logic [14:0] T_2,
    input  logic [14:0] T_7,
    input  logic [2:0]  SECTOR,
    output logic [2:0]  GATE,
    output logic [2:0]  SEG,
    output logic        SAMPLE,
    output logic        ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_TAST - 1);
    localparam logic [SUM_W-1:0] T_TAST_S = SUM_W'(T_TAST);

    tset_t            in_set, pend, act, sel;
    logic             pend_vld, run, accept, load;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SUM_W-1:0] sum, ta, tb, cnt_x;
    logic [SUM_W-1:0] b1, b2, b3, b4, b5, b6;
    seg_t             seg_cur;
    logic [2:0]       lut_gate;

    // Boundaries come from the set about to be loaded on the CNT=0 cycle, so the
    // first segment of a new period already uses the new times.
    always_comb begin
        in_set = '{sector: SECTOR, t0: T_0, t1: T_1, t2: T_2, t7: T_7};
        sum    = widen(T_0) + widen(T_1) + widen(T_2) + widen(T_7);
        accept = T_VALID && (SECTOR != 3'd0) && (SECTOR != 3'd7) && (sum <= T_TAST_S);
        load   = run && ENABLE && (cnt == '0);
        sel    = (load && pend_vld) ? pend : act;
        ta     = sel.sector[0] ? widen(sel.t1) : widen(sel.t2);
        tb     = sel.sector[0] ? widen(sel.t2) : widen(sel.t1);
        b1     = widen(sel.t0) >> 1;
        b2     = b1 + (ta >> 1);
        b3     = b2 + (tb >> 1);
        b4     = b3 + widen(sel.t7);
        b5     = b4 + (tb - (tb >> 1));
        b6     = b5 + (ta - (ta >> 1));
        cnt_x  = widen(cnt);
        if      (cnt_x >= b6) seg_cur = SEG_V0_TRAIL;
        else if (cnt_x >= b5) seg_cur = SEG_VA_TRAIL;
        else if (cnt_x >= b4) seg_cur = SEG_VB_TRAIL;
        else if (cnt_x >= b3) seg_cur = SEG_V7;
        else if (cnt_x >= b2) seg_cur = SEG_VB_LEAD;
        else if (cnt_x >= b1) seg_cur = SEG_VA_LEAD;
        else                  seg_cur = SEG_V0_LEAD;
        if (!ENABLE || !run || (cnt == CNT_LAST)) cnt_nxt = '0;
        else                                      cnt_nxt = cnt + CNT_W'(1);
    end

    ac_motor_svm_vector_lut u_lut (
        .sector (sel.sector),
        .seg    (seg_cur),
        .gate   (lut_gate)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= '0;
            run      <= 1'b0;
            GATE     <= '0;
            SEG      <= '0;
            SAMPLE   <= 1'b0;
            ERR      <= 1'b0;
            pend     <= '0;
            pend_vld <= 1'b0;
            act      <= TSET_IDLE;
        end else begin
            cnt    <= cnt_nxt;
            run    <= ENABLE;
            SAMPLE <= ENABLE && (cnt_nxt == '0);
            GATE   <= (run && ENABLE) ? lut_gate : '0;
            SEG    <= (run && ENABLE) ? seg_cur : SEG_V0_LEAD;
            if (load && pend_vld) begin
                act      <= sel;
                pend_vld <= 1'b0;
            end
            if (accept) begin
                pend     <= in_set;
                pend_vld <= 1'b1;
                ERR      <= 1'b0;
            end else if (T_VALID) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ac_motor_svm_sequencer.sv
// Directed bench for ac_motor_svm_sequencer at T_TAST=2000 with hand-computed
// segment boundaries and gate codes.
module tb_ac_motor_svm_sequencer;

    localparam int T = 2000;
    localparam int N = 11;

    typedef struct packed {
        logic [5:0][16:0] b;
        logic [6:0][2:0]  code;
    } pat_t;

    typedef struct {
        string       name;
        logic [2:0]  sector;
        logic [14:0] t0, t1, t2, t7;
        logic        exp_err;
        pat_t        pat;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N, ENABLE, T_VALID;
    logic [14:0] T_0, T_1, T_2, T_7;
    logic [2:0]  SECTOR, GATE, SEG;
    logic        SAMPLE, ERR;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[N];
    pat_t cur, zero_pat;

    always #5 CLK = ~CLK;

    ac_motor_svm_sequencer #(.F_CLK(10_000_000), .F_TAST(5_000)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .T_VALID(T_VALID),
        .T_0(T_0), .T_1(T_1), .T_2(T_2), .T_7(T_7), .SECTOR(SECTOR),
        .GATE(GATE), .SEG(SEG), .SAMPLE(SAMPLE), .ERR(ERR)
    );

    function automatic pat_t mkpat(input int b1, b2, b3, b4, b5, b6,
                                   input int c0, c1, c2, c3, c4, c5, c6);
        pat_t p;
        p.b[0] = 17'(b1); p.b[1] = 17'(b2); p.b[2] = 17'(b3);
        p.b[3] = 17'(b4); p.b[4] = 17'(b5); p.b[5] = 17'(b6);
        p.code[0] = 3'(c0); p.code[1] = 3'(c1); p.code[2] = 3'(c2); p.code[3] = 3'(c3);
        p.code[4] = 3'(c4); p.code[5] = 3'(c5); p.code[6] = 3'(c6);
        return p;
    endfunction

    function automatic vec_t mkvec(input string nm, input int s, t0, t1, t2, t7,
                                   input int e, input pat_t p);
        vec_t v;
        v.name = nm; v.sector = 3'(s);
        v.t0 = 15'(t0); v.t1 = 15'(t1); v.t2 = 15'(t2); v.t7 = 15'(t7);
        v.exp_err = 1'(e); v.pat = p;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_set(input vec_t v);
        T_VALID = 1'b1; SECTOR = v.sector;
        T_0 = v.t0; T_1 = v.t1; T_2 = v.t2; T_7 = v.t7;
    endtask

    // Entered at the negedge of a CNT=0 cycle; leaves at the next one.
    task automatic run_period(input string nm, input pat_t p, input logic offer, input vec_t v);
        int bad_g, bad_s, bad_st, bad_smp, first_bad, c, k;
        logic [2:0] prev, eg;
        bad_g = 0; bad_s = 0; bad_st = 0; bad_smp = 0; first_bad = -1; prev = '0;
        for (int j = 1; j <= T; j++) begin
            @(negedge CLK);
            c = j - 1;
            k = 0;
            for (int m = 0; m < 6; m++) if (c >= int'(p.b[m])) k = m + 1;
            eg = p.code[k];
            if (GATE != eg) begin
                if (bad_g == 0) first_bad = c;
                bad_g++;
            end
            if (SEG != 3'(k)) bad_s++;
            if (j >= 2 && $countones(GATE ^ prev) > 1) bad_st++;
            prev = GATE;
            if (SAMPLE != (j == T)) bad_smp++;
            if (j == 1) T_VALID = 1'b0;
            if (offer && j == 5) drive_set(v);
            if (j == 6) T_VALID = 1'b0;
            if (offer && j == 8) chk({nm, " ERR after ", v.name}, int'(ERR), int'(v.exp_err));
        end
        chk($sformatf("%s gate cycles wrong (first at cnt %0d)", nm, first_bad), bad_g, 0);
        chk({nm, " seg cycles wrong"}, bad_s, 0);
        chk({nm, " multi-leg steps"}, bad_st, 0);
        chk({nm, " sample cycles wrong"}, bad_smp, 0);
    endtask

    task automatic wait_sample(input string nm, input int exp_lat);
        int n;
        logic found;
        n = 0; found = 1'b0;
        while (n < T + 4 && !found) begin
            @(negedge CLK);
            n++;
            if (SAMPLE) found = 1'b1;
        end
        chk({nm, " sample latency"}, found ? n : 0, exp_lat);
    endtask

    initial begin
        vecs[0]  = mkvec("s1 base",   1, 200, 600, 400, 200, 0,
                         mkpat(100, 400, 600, 800, 1000, 1300, 0, 4, 6, 7, 6, 4, 0));
        vecs[1]  = mkvec("s2 base",   2, 200, 600, 400, 200, 0,
                         mkpat(100, 300, 600, 800, 1100, 1300, 0, 2, 6, 7, 6, 2, 0));
        vecs[2]  = mkvec("s1 odd t1", 1, 0, 301, 0, 0, 0,
                         mkpat(0, 150, 150, 150, 150, 301, 0, 4, 6, 7, 6, 4, 0));
        vecs[3]  = mkvec("sum 2400",  1, 800, 800, 800, 0, 1, zero_pat);
        vecs[4]  = mkvec("sector 7",  7, 100, 100, 100, 100, 1, zero_pat);
        vecs[5]  = mkvec("s6 wrap",   6, 100, 200, 300, 50, 0,
                         mkpat(50, 200, 300, 350, 450, 600, 0, 4, 5, 7, 5, 4, 0));
        vecs[6]  = mkvec("s4 full",   4, 0, 1000, 1000, 0, 0,
                         mkpat(0, 500, 1000, 1000, 1500, 2000, 0, 1, 3, 7, 3, 1, 0));
        vecs[7]  = mkvec("sum 2001",  1, 1, 1000, 1000, 0, 1, zero_pat);
        vecs[8]  = mkvec("sector 0",  0, 10, 10, 10, 10, 1, zero_pat);
        vecs[9]  = mkvec("s3 tiny",   3, 5, 7, 3, 1, 0,
                         mkpat(2, 5, 6, 7, 9, 13, 0, 2, 3, 7, 3, 2, 0));
        vecs[10] = mkvec("s5 base",   5, 400, 200, 200, 400, 0,
                         mkpat(200, 300, 400, 800, 900, 1000, 0, 1, 5, 7, 5, 1, 0));

        RST_N = 1'b0; ENABLE = 1'b0; T_VALID = 1'b0; SECTOR = '0;
        T_0 = '0; T_1 = '0; T_2 = '0; T_7 = '0;
        repeat (3) @(negedge CLK);
        chk("reset GATE", int'(GATE), 0);
        chk("reset SEG", int'(SEG), 0);
        chk("reset SAMPLE", int'(SAMPLE), 0);
        chk("reset ERR", int'(ERR), 0);
        RST_N = 1'b1;

        // Capture while idle, then start.
        @(negedge CLK); drive_set(vecs[0]);
        @(negedge CLK); T_VALID = 1'b0;
        @(negedge CLK);
        chk("idle ERR", int'(ERR), 0);
        chk("idle GATE", int'(GATE), 0);
        chk("idle SAMPLE", int'(SAMPLE), 0);
        ENABLE = 1'b1;
        wait_sample("enable start", 1);

        cur = vecs[0].pat;
        for (int i = 1; i <= N; i++) begin
            run_period($sformatf("period %0d", i), cur, i < N, vecs[i < N ? i : 0]);
            if (i < N && !vecs[i].exp_err) cur = vecs[i].pat;
        end

        // Set offered on the CNT=0 cycle, then overwritten later in the same period.
        drive_set(vecs[1]);
        run_period("cnt0 offer period", cur, 1'b1, vecs[0]);
        run_period("second set wins", vecs[0].pat, 1'b0, vecs[0]);

        repeat (700) @(negedge CLK);
        chk("pre-disable GATE", int'(GATE), 7);
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("disable GATE", int'(GATE), 0);
        chk("disable SEG", int'(SEG), 0);
        repeat (3) @(negedge CLK);
        chk("disable SAMPLE", int'(SAMPLE), 0);
        ENABLE = 1'b1;
        wait_sample("re-enable", 1);
        run_period("after re-enable", vecs[0].pat, 1'b0, vecs[0]);

        repeat (700) @(negedge CLK);
        chk("pre-reset GATE", int'(GATE), 7);
        RST_N = 1'b0;
        #1;
        chk("async reset GATE", int'(GATE), 0);
        chk("async reset SEG", int'(SEG), 0);
        @(negedge CLK);
        chk("in reset SAMPLE", int'(SAMPLE), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_sample("post reset", 1);
        zero_pat = mkpat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_period("post reset all-V0", zero_pat, 1'b0, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
